// File: rtl/disp_weight_if.sv
// Handshake bus for disp_weight_unit: tile beats in, weighted disparity results out.
interface disp_weight_if #(
  parameter int DISP_BITS = 5,
  parameter int CONF_BITS = 8,
  parameter int DEC       = 2
);
  localparam int POP_W = $clog2(DEC * DEC) + 1;

  logic                           in_valid;
  logic                           in_ready;
  logic                           in_sof;
  logic [DEC-1:0]                 mask_in;
  logic [DISP_BITS-1:0]           disp_in;
  logic [CONF_BITS-1:0]           conf_in;
  logic                           out_valid;
  logic                           out_ready;
  logic [DISP_BITS+CONF_BITS-1:0] wdisp_out;
  logic [CONF_BITS-1:0]           weight_out;
  logic [POP_W-1:0]               pop_out;

  modport master (
    output in_valid, in_sof, mask_in, disp_in, conf_in, out_ready,
    input  in_ready, out_valid, wdisp_out, weight_out, pop_out
  );

  modport slave (
    input  in_valid, in_sof, mask_in, disp_in, conf_in, out_ready,
    output in_ready, out_valid, wdisp_out, weight_out, pop_out
  );
endinterface

// File: rtl/disp_weight_unit.sv
// Tile popcount, confidence weighting and weighted-disparity stage (S1/S2/output pipeline).
// Optional tile statistics counters are enabled by defining DISP_WEIGHT_STATS_EN.
module disp_weight_unit #(
  parameter int DISP_BITS       = 5,
  parameter int CONF_BITS       = 8,
  parameter int DEC             = 2,
  parameter int MASK_ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CONF_BITS-1:0] min_conf,
  disp_weight_if.slave         bus
`ifdef DISP_WEIGHT_STATS_EN
  ,
  output logic [15:0]          tile_count,
  output logic [15:0]          zero_weight_count
`endif
);
  localparam int POP_W  = $clog2(DEC * DEC) + 1;
  localparam int BEAT_W = $clog2(DEC);
  localparam int SHIFT  = 2 * $clog2(DEC);
  localparam int PROD_W = POP_W + CONF_BITS;
  localparam int WD_W   = DISP_BITS + CONF_BITS;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(DEC - 1);

  function automatic logic [POP_W-1:0] count_active(input logic [DEC-1:0] m);
    logic [DEC-1:0]   act;
    logic [POP_W-1:0] c;
    act = (MASK_ACTIVE_LOW != 0) ? ~m : m;
    c   = {POP_W{1'b0}};
    for (int i = 0; i < DEC; i++) begin
      c = c + POP_W'(act[i]);
    end
    return c;
  endfunction

  logic                 en_s;
  logic                 fire_s;
  logic [BEAT_W-1:0]    base_beat_s;
  logic                 last_s;
  logic [BEAT_W-1:0]    next_beat_s;
  logic [POP_W-1:0]     cnt_s;
  logic [POP_W-1:0]     sum_s;
  logic [CONF_BITS-1:0] conf_eff_s;
  logic [PROD_W-1:0]    prod_s;
  logic [CONF_BITS-1:0] weight_s;
  logic [WD_W-1:0]      wdisp_s;

  logic [BEAT_W-1:0]    beat_r;
  logic [POP_W-1:0]     acc_r;
  logic                 s1_valid_r;
  logic [POP_W-1:0]     s1_pop_r;
  logic [DISP_BITS-1:0] s1_disp_r;
  logic [CONF_BITS-1:0] s1_conf_r;
  logic                 s2_valid_r;
  logic [POP_W-1:0]     s2_pop_r;
  logic [DISP_BITS-1:0] s2_disp_r;
  logic [CONF_BITS-1:0] s2_weight_r;
  logic                 out_valid_r;
  logic [WD_W-1:0]      wdisp_r;
  logic [CONF_BITS-1:0] weight_r;
  logic [POP_W-1:0]     pop_r;

  // Beat bookkeeping, conf floor gating and the two arithmetic stages.
  always_comb begin
    en_s        = !out_valid_r || bus.out_ready;
    fire_s      = bus.in_valid && en_s;
    // A start-of-frame beat is beat 0 regardless of where the counter was.
    base_beat_s = bus.in_sof ? {BEAT_W{1'b0}} : beat_r;
    last_s      = (base_beat_s == LAST_BEAT);
    next_beat_s = last_s ? {BEAT_W{1'b0}} : (base_beat_s + BEAT_W'(1));
    cnt_s       = count_active(bus.mask_in);
    if (base_beat_s == {BEAT_W{1'b0}}) begin
      sum_s = cnt_s;
    end else begin
      sum_s = acc_r + cnt_s;
    end
    if (bus.conf_in < min_conf) begin
      conf_eff_s = {CONF_BITS{1'b0}};
    end else begin
      conf_eff_s = bus.conf_in;
    end
    // pop <= DEC*DEC, so the shifted product never exceeds conf_eff.
    prod_s   = PROD_W'(s1_pop_r) * PROD_W'(s1_conf_r);
    weight_s = CONF_BITS'(prod_s >> SHIFT);
    wdisp_s  = WD_W'(s2_disp_r) * WD_W'(s2_weight_r);
  end

  // Beat counter, accumulator and pipeline registers; everything freezes when !en.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_r      <= {BEAT_W{1'b0}};
      acc_r       <= {POP_W{1'b0}};
      s1_valid_r  <= 1'b0;
      s1_pop_r    <= {POP_W{1'b0}};
      s1_disp_r   <= {DISP_BITS{1'b0}};
      s1_conf_r   <= {CONF_BITS{1'b0}};
      s2_valid_r  <= 1'b0;
      s2_pop_r    <= {POP_W{1'b0}};
      s2_disp_r   <= {DISP_BITS{1'b0}};
      s2_weight_r <= {CONF_BITS{1'b0}};
      out_valid_r <= 1'b0;
      wdisp_r     <= {WD_W{1'b0}};
      weight_r    <= {CONF_BITS{1'b0}};
      pop_r       <= {POP_W{1'b0}};
    end else if (en_s) begin
      if (fire_s) begin
        beat_r <= next_beat_s;
        acc_r  <= sum_s;
      end
      s1_valid_r <= fire_s && last_s;
      if (fire_s && last_s) begin
        s1_pop_r  <= sum_s;
        s1_disp_r <= bus.disp_in;
        s1_conf_r <= conf_eff_s;
      end
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_pop_r    <= s1_pop_r;
        s2_disp_r   <= s1_disp_r;
        s2_weight_r <= weight_s;
      end
      out_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        wdisp_r  <= wdisp_s;
        weight_r <= s2_weight_r;
        pop_r    <= s2_pop_r;
      end
    end
  end

  assign bus.in_ready   = en_s;
  assign bus.out_valid  = out_valid_r;
  assign bus.wdisp_out  = wdisp_r;
  assign bus.weight_out = weight_r;
  assign bus.pop_out    = pop_r;

`ifdef DISP_WEIGHT_STATS_EN
  logic        hs_s;
  logic        clr_s;
  logic        zero_s;
  logic [15:0] tile_cnt_r;
  logic [15:0] zero_cnt_r;

  // Output handshake events and the start-of-frame clear.
  always_comb begin
    hs_s   = out_valid_r && bus.out_ready;
    clr_s  = fire_s && bus.in_sof;
    zero_s = hs_s && (weight_r == {CONF_BITS{1'b0}});
  end

  // Saturating statistics; a clear coinciding with an increment leaves a count of 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      tile_cnt_r <= 16'h0000;
      zero_cnt_r <= 16'h0000;
    end else begin
      if (clr_s) begin
        tile_cnt_r <= hs_s ? 16'h0001 : 16'h0000;
      end else if (hs_s && (tile_cnt_r != 16'hFFFF)) begin
        tile_cnt_r <= tile_cnt_r + 16'h0001;
      end
      if (clr_s) begin
        zero_cnt_r <= zero_s ? 16'h0001 : 16'h0000;
      end else if (zero_s && (zero_cnt_r != 16'hFFFF)) begin
        zero_cnt_r <= zero_cnt_r + 16'h0001;
      end
    end
  end

  assign tile_count        = tile_cnt_r;
  assign zero_weight_count = zero_cnt_r;
`endif
endmodule
